// File: rtl/acq_search.sv
// Acquisition search controller: sweeps one tracking channel over a grid of
// Doppler bins and code-phase offsets, keeps the strongest early/prompt/late
// correlation seen, and reports it with a detection flag when the sweep ends.
module acq_search #(
  parameter int                         DOPPLER_WIDTH = 16,
  parameter int                         I2Q2_WIDTH    = 32,
  parameter int                         CS_WIDTH      = 14,
  parameter int                         CODE_SPAN     = 16368,
  parameter int                         CODE_STEP     = 3,
  parameter int                         EL_SPACING    = 1,
  parameter int                         NUM_BINS      = 21,
  parameter logic [DOPPLER_WIDTH-1:0]   DOPPLER_START = 16'hF000,
  parameter logic [DOPPLER_WIDTH-1:0]   DOPPLER_STEP  = 16'h0100,
  parameter int                         SKIP          = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [I2Q2_WIDTH-1:0]    threshold,
  input  logic                     i2q2_valid,
  input  logic [I2Q2_WIDTH-1:0]    i2q2_early,
  input  logic [I2Q2_WIDTH-1:0]    i2q2_prompt,
  input  logic [I2Q2_WIDTH-1:0]    i2q2_late,
  input  logic [CS_WIDTH-1:0]      code_shift,
  output logic [DOPPLER_WIDTH-1:0] doppler,
  output logic                     seek_en,
  output logic [CS_WIDTH-1:0]      seek_target,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [I2Q2_WIDTH-1:0]    best_power,
  output logic [CS_WIDTH-1:0]      best_code,
  output logic [4:0]               best_bin
);

  localparam int                SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [CS_WIDTH:0] SPAN_X = (CS_WIDTH+1)'(CODE_SPAN);
  localparam logic [CS_WIDTH:0] STEP_X = (CS_WIDTH+1)'(CODE_STEP);
  localparam logic [CS_WIDTH:0] EL_X   = (CS_WIDTH+1)'(EL_SPACING);
  localparam logic [5:0]        BINS_X = 6'(NUM_BINS);

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_WAIT_SEEK, S_DWELL, S_EVAL, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CS_WIDTH-1:0]      target_q, target_d;
  logic [4:0]               bin_q, bin_d;
  logic [DOPPLER_WIDTH-1:0] doppler_q, doppler_d;
  logic [SKIP_W-1:0]        skip_q, skip_d;
  logic                     seek_en_q, seek_en_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     found_q, found_d;
  logic [I2Q2_WIDTH-1:0]    best_power_q, best_power_d;
  logic [CS_WIDTH-1:0]      best_code_q, best_code_d;
  logic [4:0]               best_bin_q, best_bin_d;
  logic [I2Q2_WIDTH-1:0]    early_q, prompt_q, late_q;
  logic                     capture;
  logic [I2Q2_WIDTH-1:0]    cand_pow;
  logic [CS_WIDTH-1:0]      cand_code;
  logic [CS_WIDTH:0]        tgt_step;
  logic [5:0]               bin_inc;

  // Early tap sits EL_SPACING behind prompt, modulo the code span.
  function automatic logic [CS_WIDTH-1:0] wrap_sub(input logic [CS_WIDTH-1:0] t);
    logic [CS_WIDTH:0] x;
    x = {1'b0, t};
    if (x < EL_X) x = x + SPAN_X - EL_X;
    else          x = x - EL_X;
    return x[CS_WIDTH-1:0];
  endfunction

  // Late tap sits EL_SPACING ahead of prompt, modulo the code span.
  function automatic logic [CS_WIDTH-1:0] wrap_add(input logic [CS_WIDTH-1:0] t);
    logic [CS_WIDTH:0] x;
    x = {1'b0, t} + EL_X;
    if (x >= SPAN_X) x = x - SPAN_X;
    return x[CS_WIDTH-1:0];
  endfunction

  // Pick this dwell's candidate: strongest tap, prompt then early winning ties.
  always_comb begin
    if (prompt_q >= early_q && prompt_q >= late_q) begin
      cand_pow  = prompt_q;
      cand_code = target_q;
    end else if (early_q >= late_q) begin
      cand_pow  = early_q;
      cand_code = wrap_sub(target_q);
    end else begin
      cand_pow  = late_q;
      cand_code = wrap_add(target_q);
    end
    tgt_step = {1'b0, target_q} + STEP_X;
    bin_inc  = {1'b0, bin_q} + 6'd1;
  end

  // Next-state and output logic; abort overrides everything and freezes results.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    bin_d        = bin_q;
    doppler_d    = doppler_q;
    skip_d       = skip_q;
    seek_en_d    = 1'b0;
    done_d       = 1'b0;
    found_d      = found_q;
    best_power_d = best_power_q;
    best_code_d  = best_code_q;
    best_bin_d   = best_bin_q;
    capture      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          best_power_d = '0;
          best_code_d  = '0;
          best_bin_d   = '0;
          found_d      = 1'b0;
          bin_d        = '0;
          target_d     = '0;
          doppler_d    = DOPPLER_START;
          state_d      = S_SEEK;
        end
      end
      S_SEEK: begin
        seek_en_d = 1'b1;
        state_d   = S_WAIT_SEEK;
      end
      S_WAIT_SEEK: begin
        if (!seek_en_q && code_shift == target_q) begin
          skip_d  = SKIP_W'(SKIP);
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (i2q2_valid) begin
          if (skip_q != '0) begin
            skip_d = skip_q - SKIP_W'(1);
          end else begin
            capture = 1'b1;
            state_d = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        if (cand_pow > best_power_q) begin
          best_power_d = cand_pow;
          best_code_d  = cand_code;
          best_bin_d   = bin_q;
        end
        state_d = S_SEEK;
        if (tgt_step >= SPAN_X) begin
          target_d  = '0;
          bin_d     = bin_inc[4:0];
          doppler_d = doppler_q + DOPPLER_STEP;
          if (bin_inc == BINS_X) state_d = S_DONE;
        end else begin
          target_d = tgt_step[CS_WIDTH-1:0];
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        found_d = (best_power_q >= threshold);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d      = S_IDLE;
      seek_en_d    = 1'b0;
      done_d       = 1'b0;
      capture      = 1'b0;
      target_d     = target_q;
      bin_d        = bin_q;
      doppler_d    = doppler_q;
      found_d      = found_q;
      best_power_d = best_power_q;
      best_code_d  = best_code_q;
      best_bin_d   = best_bin_q;
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      bin_q        <= '0;
      doppler_q    <= DOPPLER_START;
      skip_q       <= '0;
      seek_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      best_power_q <= '0;
      best_code_q  <= '0;
      best_bin_q   <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      bin_q        <= bin_d;
      doppler_q    <= doppler_d;
      skip_q       <= skip_d;
      seek_en_q    <= seek_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      found_q      <= found_d;
      best_power_q <= best_power_d;
      best_code_q  <= best_code_d;
      best_bin_q   <= best_bin_d;
    end
  end

  // Hold the measurement pulse's three correlator results for evaluation.
  always_ff @(posedge clk) begin
    if (capture) begin
      early_q  <= i2q2_early;
      prompt_q <= i2q2_prompt;
      late_q   <= i2q2_late;
    end
  end

  assign doppler     = doppler_q;
  assign seek_en     = seek_en_q;
  assign seek_target = target_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign best_power  = best_power_q;
  assign best_code   = best_code_q;
  assign best_bin    = best_bin_q;

endmodule

// File: doc/acq_search.md
# acq_search

Acquisition search controller that drives one tracking channel through a two-dimensional Doppler/code-phase sweep and picks the strongest correlation. It issues Doppler settings and code-phase seek commands to the channel, consumes the channel's early/prompt/late I²+Q² results on each valid pulse, and reports the best cell with a detection flag. Sits between the top-level control logic and a channel operating in acquisition mode.

## Interface
- DOPPLER_WIDTH, 16: width of the Doppler increment word driven to the channel.
- I2Q2_WIDTH, 32: width of the channel's I²+Q² results.
- CS_WIDTH, 14: width of code shift / seek target.
- CODE_SPAN, 16368: code-phase modulus; legal shifts are 0..CODE_SPAN-1.
- CODE_STEP, 3: code-shift increment between dwells.
- EL_SPACING, 1: offset of the early/late taps from prompt, in code-shift units.
- NUM_BINS, 21: number of Doppler bins swept.
- DOPPLER_START, 16'hF000: Doppler increment for bin 0 (two's complement).
- DOPPLER_STEP, 16'h0100: Doppler increment added per bin.
- SKIP, 1: valid pulses discarded after each seek.
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a search; honoured only in IDLE.
- abort  in  1  terminates a search; return to IDLE next cycle.
- threshold  in  I2Q2_WIDTH  detection threshold.
- i2q2_valid  in  1  channel result strobe.
- i2q2_early / i2q2_prompt / i2q2_late  in  I2Q2_WIDTH each  channel results, stable while i2q2_valid high.
- code_shift  in  CS_WIDTH  channel's current prompt code shift.
- doppler  out  DOPPLER_WIDTH  increment driven to all three subchannels; reset DOPPLER_START.
- seek_en  out  1  one-cycle seek request; reset 0.
- seek_target  out  CS_WIDTH  seek target; reset 0.
- busy  out  1  high outside IDLE/DONE; reset 0.
- done  out  1  one-cycle pulse on completion; reset 0.
- found  out  1  best_power >= threshold, updated at done; reset 0.
- best_power  out  I2Q2_WIDTH  reset 0.
- best_code  out  CS_WIDTH  reset 0.
- best_bin  out  5  reset 0.

## Operation
- States: IDLE, SEEK, WAIT_SEEK, DWELL, EVAL, DONE.
- IDLE: start -> clear best_*, found; bin=0, target=0, doppler=DOPPLER_START; -> SEEK.
- SEEK: assert seek_en for exactly one cycle with seek_target=target; -> WAIT_SEEK.
- WAIT_SEEK: leave when code_shift==seek_target, no earlier than the cycle after seek_en; load skip counter=SKIP; -> DWELL.
- DWELL: each i2q2_valid decrements the skip counter while it is nonzero; the first valid seen with counter zero latches the three results; -> EVAL.
- EVAL (one cycle): candidate = max of E/P/L; tie priority prompt > early > late. Candidate code: prompt=target, early=(target-EL_SPACING) mod CODE_SPAN, late=(target+EL_SPACING) mod CODE_SPAN. Replace best only if candidate strictly greater than best_power (earlier cell wins ties). Then advance: target+=CODE_STEP; if new target >= CODE_SPAN, target=0, bin+=1, doppler+=DOPPLER_STEP (wrapping two's-complement add). If bin reaches NUM_BINS -> DONE, else -> SEEK.
- DONE: pulse done, set found, -> IDLE. best_* hold until the next start.
- abort in any state: seek_en forced 0, -> IDLE next cycle, best_* retain partial results, no done pulse.
- reset_n low: all state and outputs to reset values next edge, regardless of state.

## Timing
- start -> seek_en high: 2 cycles (IDLE->SEEK registered, seek_en registered).
- Doppler output changes only in the EVAL->SEEK transition, ahead of the seek.
- i2q2_valid outside DWELL is ignored.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- Simultaneous abort and i2q2_valid in DWELL: abort wins, no best_* update.
- All outputs registered; no combinational path input to output.

## Test plan
- Reset: hold reset_n low 3 cycles mid-DWELL -> all outputs reset values, state IDLE, doppler=16'hF000.
- Single-peak sweep (CODE_SPAN=12, CODE_STEP=3, NUM_BINS=2, SKIP=1): model returns 100 everywhere except prompt=5000 at bin 1, target 6 -> done after 8 dwells, best_power=5000, best_code=6, best_bin=1, found=1 with threshold=1000.
- Late-tap peak: late=900 at target 9, bin 0, others 10, EL_SPACING=1 -> best_code=10; late peak at target 9 with CODE_SPAN=10 -> best_code=0 (wrap).
- Skip/ties: first valid after each seek carries 9999 -> never recorded; equal peaks 700 at bin 0 and bin 1 -> best_bin=0; E=P=L=700 -> best_code=prompt target.
- Seek handshake: code_shift lags target by 5 cycles -> exactly one seek_en pulse, DWELL entered the cycle after match.
- Abort in WAIT_SEEK and start+abort in IDLE -> IDLE next cycle, busy=0, no done, seek_en stays 0.
